// File: rtl/llr_packer_pkg.sv
// Shared types and sizing for the LLR demapper packer: LLR element type,
// symbol/word arrays and the widths derived from them.
package llr_packer_pkg;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  localparam int pBMAX  = 12;
  localparam int pLLR_W = 4;
  localparam int pWORD  = 16;

  // residue can hold a nearly-full word plus one maximal symbol
  localparam int DEPTH = pWORD + pBMAX - 1;
  localparam int CNT_W = clog2(pWORD);
  localparam int TOT_W = clog2(pWORD + pBMAX);
  localparam int IDX_W = clog2(DEPTH);
  localparam int NUM_W = clog2(pWORD + 1);

  typedef logic signed [pLLR_W-1:0] llr_t;
  typedef llr_t [pWORD-1:0] word_t;
  typedef llr_t [pBMAX-1:0] sym_t;

endpackage

// File: rtl/llr_demapper_packer_buf.sv
// Append/shift datapath: merges a symbol into the residue buffer at the
// current fill level and drops a completed word off the front.
module llr_demapper_packer_buf
  import llr_packer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             append,
  input  logic             restart,
  input  logic             clear,
  input  logic [3:0]       qam,
  input  sym_t             llr,
  output logic [CNT_W-1:0] cnt,
  output logic [TOT_W-1:0] tot,
  output word_t            merged_head,
  output word_t            head
);

  llr_t [DEPTH-1:0] buffer;
  llr_t [DEPTH-1:0] merged;
  llr_t [DEPTH-1:0] shifted;
  logic [IDX_W-1:0] idx;

  // restart treats the buffer as empty so a new frame always lands at slot 0
  always_comb begin
    merged = restart ? '0 : buffer;
    idx    = '0;
    for (int k = 0; k < pBMAX; k++) begin
      idx = IDX_W'(k) + (restart ? IDX_W'(0) : IDX_W'(cnt));
      if (4'(k) < qam) merged[idx] = llr[k];
    end
    tot = (restart ? TOT_W'(0) : TOT_W'(cnt)) + TOT_W'(qam);
    shifted = '0;
    for (int j = 0; j < DEPTH - pWORD; j++) shifted[j] = merged[j + pWORD];
  end

  assign merged_head = merged[pWORD-1:0];
  assign head        = buffer[pWORD-1:0];

  // slots beyond cnt are kept at zero so partial words come out zero padded
  always_ff @(posedge clk) begin
    if (reset) begin
      buffer <= '0;
      cnt    <= '0;
    end else if (en) begin
      if (clear) begin
        buffer <= '0;
        cnt    <= '0;
      end else if (append) begin
        if (tot >= TOT_W'(pWORD)) begin
          buffer <= shifted;
          cnt    <= CNT_W'(tot - TOT_W'(pWORD));
        end else begin
          buffer <= merged;
          cnt    <= CNT_W'(tot);
        end
      end
    end
  end

endmodule

// File: rtl/llr_demapper_packer.sv
// Packs variable-length LLR symbols into fixed pWORD-LLR words, tracking
// frame start/end and flushing a zero-padded tail word at end of frame.
module llr_demapper_packer
  import llr_packer_pkg::*;
(
  input  logic             iclk,
  input  logic             ireset,
  input  logic             iclkena,
  input  logic             ival,
  input  logic             isop,
  input  logic             ieop,
  input  logic [3:0]       iqam,
  input  sym_t             iLLR,
  output logic             oval,
  output logic             osop,
  output logic             oeop,
  output logic [NUM_W-1:0] onum,
  output word_t            oLLR,
  output logic             oerr
);

  logic             sop_pend;
  logic             flush_pend;
  logic             qam_ok;
  logic             accept;
  logic             full;
  logic             last_short;
  logic             clear;
  logic             err;
  logic [CNT_W-1:0] cnt;
  logic [TOT_W-1:0] tot;
  word_t            merged_head;
  word_t            head;

  // while a flush is pending only a new-frame symbol may be accepted
  always_comb begin
    qam_ok     = (iqam != 4'd0) && (iqam <= 4'(pBMAX));
    accept     = ival & qam_ok & (isop | ~flush_pend);
    full       = tot >= TOT_W'(pWORD);
    last_short = accept & ieop & ~full & ~flush_pend;
    clear      = (flush_pend & ~accept) | last_short;
    err        = ival & (~qam_ok | (~isop & flush_pend) |
                         (isop & ~flush_pend & (cnt != '0)));
  end

  llr_demapper_packer_buf u_buf (
    .clk         (iclk),
    .reset       (ireset),
    .en          (iclkena),
    .append      (accept),
    .restart     (isop),
    .clear       (clear),
    .qam         (iqam),
    .llr         (iLLR),
    .cnt         (cnt),
    .tot         (tot),
    .merged_head (merged_head),
    .head        (head)
  );

  always_ff @(posedge iclk) begin
    if (ireset) begin
      oval       <= 1'b0;
      osop       <= 1'b0;
      oeop       <= 1'b0;
      oerr       <= 1'b0;
      onum       <= '0;
      oLLR       <= '0;
      sop_pend   <= 1'b0;
      flush_pend <= 1'b0;
    end else if (iclkena) begin
      oerr <= err;
      oval <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
      if (flush_pend) begin
        oval       <= 1'b1;
        oeop       <= 1'b1;
        oLLR       <= head;
        onum       <= NUM_W'(cnt);
        flush_pend <= 1'b0;
        if (accept) sop_pend <= 1'b1;
      end else if (accept) begin
        if (full | ieop) begin
          oval       <= 1'b1;
          osop       <= sop_pend | isop;
          oeop       <= ieop & (tot <= TOT_W'(pWORD));
          oLLR       <= merged_head;
          onum       <= full ? NUM_W'(pWORD) : NUM_W'(tot);
          flush_pend <= ieop & (tot > TOT_W'(pWORD));
          sop_pend   <= 1'b0;
        end else begin
          sop_pend <= sop_pend | isop;
        end
      end
    end
  end

endmodule

// File: tb/tb_llr_demapper_packer.sv
// Self-checking bench for llr_demapper_packer against a queue-based model
// of the packing rules, with directed scenarios and random frames.
module tb_llr_demapper_packer;
  import llr_packer_pkg::*;

  logic             iclk = 1'b0;
  logic             ireset, iclkena, ival, isop, ieop;
  logic [3:0]       iqam;
  sym_t             iLLR;
  logic             oval, osop, oeop, oerr;
  logic [NUM_W-1:0] onum;
  word_t            oLLR;

  int checks = 0;
  int errors = 0;

  always #5 iclk = ~iclk;

  llr_demapper_packer dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .ival    (ival),
    .isop    (isop),
    .ieop    (ieop),
    .iqam    (iqam),
    .iLLR    (iLLR),
    .oval    (oval),
    .osop    (osop),
    .oeop    (oeop),
    .onum    (onum),
    .oLLR    (oLLR),
    .oerr    (oerr)
  );

  // reference model: pending LLRs as a stream queue plus frame flags
  logic [3:0]  res[$];
  bit          m_flush, m_sop;
  logic        e_val, e_sop, e_eop, e_err;
  logic [4:0]  e_num;
  logic [63:0] e_word;

  function automatic logic [72:0] exp_bus();
    return {e_val, e_sop, e_eop, e_err, e_num, e_word};
  endfunction

  function automatic logic [72:0] obs_bus();
    return {oval, osop, oeop, oerr, onum, oLLR};
  endfunction

  function automatic logic [47:0] rnd_llr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic model_reset();
    res.delete();
    m_flush = 0; m_sop = 0;
    e_val = 0; e_sop = 0; e_eop = 0; e_err = 0; e_num = '0; e_word = '0;
  endtask

  task automatic model_emit(input int n, input bit s, input bit e);
    e_val = 1; e_sop = s; e_eop = e; e_num = 5'(n); e_word = '0;
    for (int i = 0; i < n; i++) e_word[4*i +: 4] = res.pop_front();
  endtask

  task automatic model_step(input logic v, input logic s, input logic e,
                            input logic ce, input logic [3:0] q,
                            input logic [47:0] l);
    bit qok, acc;
    if (!ce) return;
    qok   = (q >= 1) && (q <= pBMAX);
    e_err = v && (!qok || (m_flush && !s) || (s && !m_flush && res.size() != 0));
    acc   = v && qok && (s || !m_flush);
    e_val = 0; e_sop = 0; e_eop = 0;
    if (m_flush) begin
      model_emit(res.size(), 0, 1);
      m_flush = 0;
      if (acc) begin
        m_sop = 1;
        for (int k = 0; k < q; k++) res.push_back(l[4*k +: 4]);
      end
    end else if (acc) begin
      if (s) begin
        res.delete();
        m_sop = 1;
      end
      for (int k = 0; k < q; k++) res.push_back(l[4*k +: 4]);
      if (res.size() >= pWORD) begin
        model_emit(pWORD, m_sop, e && res.size() == pWORD);
        m_sop = 0;
        if (e && res.size() > 0) m_flush = 1;
      end else if (e) begin
        model_emit(res.size(), m_sop, 1);
        m_sop = 0;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic e,
                       input logic ce, input logic [3:0] q, input logic [47:0] l);
    ival = v; isop = s; ieop = e; iclkena = ce; iqam = q; iLLR = l;
    model_step(v, s, e, ce, q, l);
    @(posedge iclk);
    #1;
    ival = 0; isop = 0; ieop = 0; iclkena = 1;
  endtask

  task automatic do_reset();
    ireset = 1; ival = 0; isop = 0; ieop = 0; iclkena = 1;
    model_reset();
    @(posedge iclk);
    #1;
    ireset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_bus() !== 73'd0) begin
      errors++;
      $display("[TB] FAIL reset outputs got %h want 0", obs_bus());
    end
    checks++;
    if (dut.u_buf.cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset cnt got %0d want 0", dut.u_buf.cnt);
    end
  endtask

  task automatic test_single_word();
    logic [47:0] l;
    for (int n = 0; n < 5; n++) begin
      l = '0;
      for (int k = 0; k < 4; k++) l[4*k +: 4] = 4'(4*n + k + 1);
      if (n < 4) cycle(1, n == 0, n == 3, 1, 4'd4, l);
      else cycle(0, 0, 0, 1, 4'd0, l);
      checks++;
      if (obs_bus() !== exp_bus()) begin
        errors++;
        $display("[TB] FAIL single_word cyc %0d got %h want %h", n, obs_bus(), exp_bus());
      end
    end
  endtask

  task automatic test_full_words();
    for (int n = 0; n < 6; n++) begin
      if (n < 4) cycle(1, n == 0, n == 3, 1, 4'd12, rnd_llr());
      else if (n == 4) cycle(1, 1, 1, 1, 4'd7, rnd_llr());
      else cycle(0, 0, 0, 1, 4'd0, rnd_llr());
      checks++;
      if (obs_bus() !== exp_bus()) begin
        errors++;
        $display("[TB] FAIL full_words cyc %0d got %h want %h", n, obs_bus(), exp_bus());
      end
    end
    checks++;
    if (dut.u_buf.cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL full_words cnt got %0d want 0", dut.u_buf.cnt);
    end
  endtask

  // back-to-back: flush of one frame overlaps the first symbol of the next
  task automatic test_flush_then_sop();
    for (int n = 0; n < 5; n++) begin
      if (n < 3) cycle(1, n == 0, n == 2, 1, 4'd12, rnd_llr());
      else if (n == 3) cycle(1, 1, 0, 1, 4'd5, rnd_llr());
      else cycle(0, 0, 0, 1, 4'd0, rnd_llr());
      checks++;
      if (obs_bus() !== exp_bus()) begin
        errors++;
        $display("[TB] FAIL flush_sop cyc %0d got %h want %h", n, obs_bus(), exp_bus());
      end
    end
    checks++;
    if (dut.u_buf.cnt !== 4'd5) begin
      errors++;
      $display("[TB] FAIL flush_sop cnt got %0d want 5", dut.u_buf.cnt);
    end
  endtask

  task automatic test_sop_error();
    cycle(1, 0, 0, 1, 4'd2, rnd_llr());
    checks++;
    if (dut.u_buf.cnt !== 4'd7) begin
      errors++;
      $display("[TB] FAIL sop_err precnt got %0d want 7", dut.u_buf.cnt);
    end
    for (int n = 0; n < 7; n++) begin
      case (n)
        0: cycle(1, 1, 0, 1, 4'd8, rnd_llr());
        1: cycle(1, 0, 1, 1, 4'd12, rnd_llr());
        2: cycle(1, 0, 0, 1, 4'd3, rnd_llr());
        3: cycle(0, 0, 0, 1, 4'd0, rnd_llr());
        4: cycle(1, 1, 0, 1, 4'd8, rnd_llr());
        5: cycle(1, 0, 1, 1, 4'd8, rnd_llr());
        default: cycle(0, 0, 0, 1, 4'd0, rnd_llr());
      endcase
      checks++;
      if (obs_bus() !== exp_bus()) begin
        errors++;
        $display("[TB] FAIL sop_err cyc %0d got %h want %h", n, obs_bus(), exp_bus());
      end
    end
  endtask

  task automatic test_qam_and_clkena();
    for (int n = 0; n < 10; n++) begin
      case (n)
        0: cycle(1, 1, 0, 1, 4'd3, rnd_llr());
        1: cycle(1, 0, 0, 1, 4'd0, rnd_llr());
        2: cycle(1, 0, 0, 1, 4'd13, rnd_llr());
        3: cycle(1, 0, 0, 1, 4'd12, rnd_llr());
        4, 5, 6: cycle(1, 0, 1, 0, 4'd9, rnd_llr());
        7: cycle(1, 0, 1, 1, 4'd1, rnd_llr());
        default: cycle(0, 0, 0, 1, 4'd0, rnd_llr());
      endcase
      checks++;
      if (obs_bus() !== exp_bus()) begin
        errors++;
        $display("[TB] FAIL qam_clkena cyc %0d got %h want %h", n, obs_bus(), exp_bus());
      end
      checks++;
      if (dut.u_buf.cnt !== 4'(res.size())) begin
        errors++;
        $display("[TB] FAIL qam_clkena cnt cyc %0d got %0d want %0d", n, dut.u_buf.cnt, res.size());
      end
    end
  endtask

  task automatic test_reset_midframe();
    cycle(1, 1, 0, 1, 4'd9, rnd_llr());
    checks++;
    if (dut.u_buf.cnt !== 4'd9) begin
      errors++;
      $display("[TB] FAIL rst_mid precnt got %0d want 9", dut.u_buf.cnt);
    end
    do_reset();
    checks++;
    if (obs_bus() !== 73'd0 || dut.u_buf.cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid outputs got %h cnt %0d want 0", obs_bus(), dut.u_buf.cnt);
    end
    for (int n = 0; n < 3; n++) begin
      if (n < 2) cycle(1, n == 0, n == 1, 1, 4'd8, rnd_llr());
      else cycle(0, 0, 0, 1, 4'd0, rnd_llr());
      checks++;
      if (obs_bus() !== exp_bus()) begin
        errors++;
        $display("[TB] FAIL rst_mid cyc %0d got %h want %h", n, obs_bus(), exp_bus());
      end
    end
  endtask

  task automatic test_random();
    int nsym;
    logic [3:0] q;
    for (int f = 0; f < 60; f++) begin
      nsym = $urandom_range(2, 6);
      for (int s = 0; s < nsym; s++) begin
        q = 4'($urandom_range(1, pBMAX));
        if ($urandom_range(0, 9) == 0) q = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15;
        cycle(1, s == 0, s == nsym - 1, $urandom_range(0, 7) != 0, q, rnd_llr());
        checks++;
        if (obs_bus() !== exp_bus()) begin
          errors++;
          $display("[TB] FAIL random f %0d s %0d got %h want %h", f, s, obs_bus(), exp_bus());
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        cycle(0, 0, 0, 1, 4'd0, rnd_llr());
        checks++;
        if (obs_bus() !== exp_bus()) begin
          errors++;
          $display("[TB] FAIL random idle f %0d got %h want %h", f, obs_bus(), exp_bus());
        end
      end
    end
  endtask

  initial begin
    ireset = 1; iclkena = 1; ival = 0; isop = 0; ieop = 0; iqam = '0; iLLR = '0;
    test_reset();
    test_single_word();
    test_full_words();
    test_flush_then_sop();
    test_sop_error();
    test_qam_and_clkena();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/llr_demapper_packer.md
Name: llr_demapper_packer

Overview:
- Sits directly downstream of the odd/even QAM LLR demappers.
- Consumes per-symbol LLR vectors whose useful length varies with iqam (1..pBMAX LLRs).
- Packs them, LSB-first, into fixed-width words of pWORD LLRs for the decoder input buffer.
- Tracks frame boundaries; flushes a zero-padded partial word at end of frame.

Parameters:
- pBMAX, 12, max LLRs per symbol (iLLR array size).
- pLLR_W, 4, LLR width in bits.
- pWORD, 16, LLRs per output word. Constraint: pWORD >= pBMAX, so at most one full word forms per input cycle.

Ports:
- iclk  in  1  clock
- ireset  in  1  reset, synchronous, active-high
- iclkena  in  1  clock enable; all state holds when low
- ival  in  1  input symbol valid
- isop  in  1  first symbol of frame (qualified by ival)
- ieop  in  1  last symbol of frame (qualified by ival)
- iqam  in  4  number of valid LLRs in iLLR (bits per symbol)
- iLLR  in  pLLR_W x pBMAX  signed LLRs; index 0 first in stream order
- oval  out  1  output word valid
- osop  out  1  first word of frame
- oeop  out  1  last word of frame
- onum  out  clog2(pWORD+1)  valid LLRs in oLLR (pWORD except possibly the last word)
- oLLR  out  pLLR_W x pWORD  packed word; index 0 oldest; invalid slots are 0
- oerr  out  1  one-cycle error pulse

Behaviour:
- Reset values: oval, osop, oeop, oerr = 0; onum = 0; oLLR = all 0. Internal state also clears: residue count cnt = 0, residue buffer = 0, sop_pend = 0, flush_pend = 0.
- Reset mid-frame discards the residue; no flush word is produced.
- Residue buffer holds pWORD+pBMAX-1 LLRs. cnt is in 0..pWORD-1 between symbols.
- Accepted symbol (ival & iclkena, 1 <= iqam <= pBMAX):
  - iLLR[0..iqam-1] is appended at buffer position cnt (isop forces the base to 0). Let tot = base + iqam.
  - If tot >= pWORD: next cycle, oval = 1, oLLR = first pWORD entries, onum = pWORD. Remaining tot-pWORD entries shift to the front; cnt <= tot-pWORD.
  - If tot < pWORD: cnt <= tot, no output.
- Latency: output word registered 1 cycle after the input that completes it.
- osop: sop_pend is set on isop and cleared by the first word emitted for that frame; osop = sop_pend on that word.
- ieop:
  - After the append, all residue must leave.
  - If tot < pWORD: a single word with onum = tot, zero padded, oeop = 1, issued 1 cycle later.
  - If tot == pWORD: the full word carries oeop = 1.
  - If tot > pWORD: the full word goes out at +1 with oeop = 0. flush_pend is set and the remainder word (onum = tot-pWORD, oeop = 1) goes out at +2.
  - A one-symbol frame (isop & ieop together) is legal.
- Flush vs. new frame: the cycle after ieop may carry a new isop symbol. Its tot <= pBMAX < pWORD, so no output conflict arises. The flush word and the new append proceed in the same cycle.
  - A non-sop symbol arriving while flush_pend is set is a protocol error: oerr = 1, the symbol is dropped.
- isop while cnt != 0 (previous frame lacked ieop): oerr = 1, residue discarded, new frame starts normally.
- iqam == 0 or iqam > pBMAX with ival: oerr = 1, symbol ignored, state unchanged.
- oval deasserts on any cycle with nothing to emit. oLLR/onum are don't-care when oval = 0 but held at the last value.
- iclkena = 0: no state update and outputs hold. oval stays at its last value; the consumer qualifies it with iclkena.

Decomposition:
- Shared package llr_packer_pkg: LLR type (signed pLLR_W), typedef for word array, function clog2.
- Sub-module llr_demapper_packer_buf: the append/shift datapath (buffer, cnt, tot computation), one registered stage.
- The top holds sop/eop/flush control and output registers.

Test Plan:
- pWORD=16, four iqam=4 symbols with LLR values 1..16, isop on the first, ieop on the last -> one word 1 cycle after the 4th symbol; oLLR = 1..16, onum = 16, osop = oeop = 1.
- Four iqam=12 symbols, sop..eop -> words after symbols 2, 3 and 4. The last word has onum = 16, oeop = 1; no flush cycle; cnt returns to 0.
- Three iqam=12 symbols with ieop on the 3rd, followed next cycle by an isop iqam=5 symbol -> full word at +1 with oeop = 0; flush word onum = 4, oeop = 1, slots 4..15 = 0 at +2. The new frame's residue cnt = 5 is retained.
- isop arrives with cnt = 7 -> oerr pulse; the old 7 LLRs never appear; the next frame's words are correct.
- iqam = 0 and iqam = 13 with ival -> oerr pulse, no oval, cnt unchanged. iclkena = 0 for 3 cycles mid-frame -> outputs and cnt frozen, stream resumes bit-exact.
- ireset asserted mid-frame with cnt = 9 -> next cycle all outputs 0 and cnt = 0. A following sop frame of two iqam=8 symbols gives a single word, onum = 16, osop = 1.
